// File: rtl/video_timing_pkg.sv
// Shared raster constants for the VT52 display pipeline (640x480@60 defaults).
package video_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_X_BITS   = 10;
    localparam int DEF_Y_BITS   = 10;

    // Length of one axis period in counts.
    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/video_timing_if.sv
// Raster timing bundle: pixel enable in, coordinates/flags/ticks out.
interface video_timing_if
    import video_timing_pkg::*;
#(
    parameter int X_BITS = DEF_X_BITS,
    parameter int Y_BITS = DEF_Y_BITS
);
    logic              pix_ce;
    logic [X_BITS-1:0] x;
    logic [Y_BITS-1:0] y;
    logic              hsync;
    logic              vsync;
    logic              hblank;
    logic              vblank;
    logic              active;
    logic              line_tick;
    logic              frame_tick;

    modport master (
        input  pix_ce,
        output x, y, hsync, vsync, hblank, vblank, active, line_tick, frame_tick
    );

    modport slave (
        output pix_ce,
        input  x, y, hsync, vsync, hblank, vblank, active, line_tick, frame_tick
    );
endinterface

// File: rtl/video_axis_counter.sv
// One raster axis: wrapping counter plus blank/sync decode of the next count.
module video_axis_counter
    import video_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int BITS   = DEF_X_BITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    output logic [BITS-1:0] count,
    output logic            wrap,
    output logic [BITS-1:0] next_count,
    output logic            blank,
    output logic            sync_active
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [BITS-1:0] LAST = BITS'(TOTAL - 1);

    // Region bounds are one bit wider so the sync end may equal TOTAL
    // (zero back porch) without aliasing to zero.
    localparam logic [BITS:0] W_ACTIVE     = (BITS+1)'(ACTIVE);
    localparam logic [BITS:0] W_SYNC_START = (BITS+1)'(ACTIVE + FP);
    localparam logic [BITS:0] W_SYNC_END   = (BITS+1)'(ACTIVE + FP + SYNC);

    logic [BITS:0] next_wide;

    // Next count and the flags it implies, so outputs line up with the count.
    always_comb begin
        wrap       = en && (count == LAST);
        next_count = count;
        if (en) begin
            next_count = (count == LAST) ? '0 : count + 1'b1;
        end
        next_wide   = {1'b0, next_count};
        blank       = (next_wide >= W_ACTIVE);
        sync_active = (next_wide >= W_SYNC_START) && (next_wide < W_SYNC_END);
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= next_count;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: chains h and v axis counters and registers the flags.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int X_BITS    = DEF_X_BITS,
    parameter int Y_BITS    = DEF_Y_BITS
) (
    input  logic           clk,
    input  logic           reset,
    video_timing_if.master vid
);

    localparam logic [Y_BITS-1:0] V_ACT_L = Y_BITS'(V_ACTIVE);

    logic [X_BITS-1:0] h_count;
    logic [X_BITS-1:0] h_next;
    logic              h_wrap;
    logic              h_blank;
    logic              h_sync;

    logic              v_en;
    logic [Y_BITS-1:0] v_count;
    logic [Y_BITS-1:0] v_next;
    logic              v_wrap;
    logic              v_blank;
    logic              v_sync;

    logic              frame_hit;

    video_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .BITS   (X_BITS)
    ) u_h (
        .clk         (clk),
        .reset       (reset),
        .en          (vid.pix_ce),
        .count       (h_count),
        .wrap        (h_wrap),
        .next_count  (h_next),
        .blank       (h_blank),
        .sync_active (h_sync)
    );

    video_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .BITS   (Y_BITS)
    ) u_v (
        .clk         (clk),
        .reset       (reset),
        .en          (v_en),
        .count       (v_count),
        .wrap        (v_wrap),
        .next_count  (v_next),
        .blank       (v_blank),
        .sync_active (v_sync)
    );

    // Vertical step on each line wrap; frame tick on entry into vertical blank,
    // never on the end-of-frame wrap back to line 0.
    always_comb begin
        v_en      = h_wrap && vid.pix_ce;
        frame_hit = v_en && !v_wrap && (v_next == V_ACT_L);
    end

    // h_next is the value the h counter loads, i.e. x after this edge.
    assign vid.x = h_count;
    assign vid.y = v_count;

    // Registered sync polarity, blanking and tick outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            vid.hsync      <= ~HSYNC_POL;
            vid.vsync      <= ~VSYNC_POL;
            vid.hblank     <= 1'b0;
            vid.vblank     <= 1'b0;
            vid.active     <= 1'b1;
            vid.line_tick  <= 1'b0;
            vid.frame_tick <= 1'b0;
        end else begin
            vid.hsync      <= h_sync ? HSYNC_POL : ~HSYNC_POL;
            vid.vsync      <= v_sync ? VSYNC_POL : ~VSYNC_POL;
            vid.hblank     <= h_blank;
            vid.vblank     <= v_blank;
            vid.active     <= ~h_blank & ~v_blank;
            vid.line_tick  <= h_wrap;
            vid.frame_tick <= frame_hit;
        end
    end

    // h_next feeds the h register inside u_h; exposing it keeps the counter
    // interface uniform for both axes.
    logic unused_h_next;
    assign unused_h_next = ^h_next;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: default 640x480 instance plus a tiny 7x5 raster instance.
module tb_video_timing_gen;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [6:0]  f;   // hsync, vsync, hblank, vblank, active, line_tick, frame_tick
    } exp_t;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
    } cfg_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d = 1'b1;
    logic rst_s = 1'b1;

    video_timing_if #(.X_BITS(10), .Y_BITS(10)) vd ();
    video_timing_if #(.X_BITS(3),  .Y_BITS(3))  vsm ();

    video_timing_gen dut_d (
        .clk   (clk),
        .reset (rst_d),
        .vid   (vd)
    );

    video_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
        .V_ACTIVE (3), .V_FP (0), .V_SYNC (1), .V_BP (1),
        .X_BITS   (3), .Y_BITS (3)
    ) dut_s (
        .clk   (clk),
        .reset (rst_s),
        .vid   (vsm)
    );

    cfg_t cfg_d = '{640, 16, 96, 48, 480, 10, 2, 33};
    cfg_t cfg_s = '{4, 1, 1, 1, 3, 0, 1, 1};

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   mdx = 0, mdy = 0, msx = 0, msy = 0;
    bit   ce_d = 1'b0, ce_s = 1'b0;
    exp_t q_d[$];
    exp_t q_s[$];

    // Behavioural raster model: advances one edge and returns expected outputs.
    function automatic exp_t model(input cfg_t c, input bit r, input bit ce,
                                   inout int mx, inout int my);
        exp_t e;
        int   ht, vt;
        bit   lt, ft, hsi, vsi, hbl, vbl;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        lt = 1'b0;
        ft = 1'b0;
        if (r) begin
            mx = 0;
            my = 0;
        end else if (ce) begin
            if (mx == ht - 1) begin
                mx = 0;
                lt = 1'b1;
                my = (my == vt - 1) ? 0 : my + 1;
                ft = (my == c.va);
            end else begin
                mx = mx + 1;
            end
        end
        hbl = (mx >= c.ha);
        vbl = (my >= c.va);
        hsi = (mx >= c.ha + c.hf) && (mx < c.ha + c.hf + c.hs);
        vsi = (my >= c.va + c.vf) && (my < c.va + c.vf + c.vs);
        e.x = 16'(mx);
        e.y = 16'(my);
        e.f = {~hsi, ~vsi, hbl, vbl, ~hbl & ~vbl, lt, ft};
        return e;
    endfunction

    // Drive one clock of stimulus, queue the expected result, settle past the edge.
    task automatic step();
        vd.pix_ce  = ce_d;
        vsm.pix_ce = ce_s;
        q_d.push_back(model(cfg_d, rst_d, ce_d, mdx, mdy));
        q_s.push_back(model(cfg_s, rst_s, ce_s, msx, msy));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every clock both DUTs present outputs; pop and compare.
    always @(negedge clk) begin
        exp_t e, a;
        if (q_d.size() > 0) begin
            e = q_d.pop_front();
            a.x = 16'(vd.x);
            a.y = 16'(vd.y);
            a.f = {vd.hsync, vd.vsync, vd.hblank, vd.vblank, vd.active, vd.line_tick, vd.frame_tick};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL sb_default t=%0t: got x=%0d y=%0d f=%b, expected x=%0d y=%0d f=%b",
                         $time, a.x, a.y, a.f, e.x, e.y, e.f);
            end
        end
        if (q_s.size() > 0) begin
            e = q_s.pop_front();
            a.x = 16'(vsm.x);
            a.y = 16'(vsm.y);
            a.f = {vsm.hsync, vsm.vsync, vsm.hblank, vsm.vblank, vsm.active, vsm.line_tick, vsm.frame_tick};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL sb_small t=%0t: got x=%0d y=%0d f=%b, expected x=%0d y=%0d f=%b",
                         $time, a.x, a.y, a.f, e.x, e.y, e.f);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_first, t_second, t_rel;
        bit found;

        // ---- default instance: reset 3 clocks (small held in reset with ce=1)
        rst_d = 1'b1; ce_d = 1'b0;
        rst_s = 1'b1; ce_s = 1'b1;
        repeat (3) step();
        chk("rst_x", int'(vd.x), 0);
        chk("rst_y", int'(vd.y), 0);
        chk("rst_hsync", int'(vd.hsync), 1);
        chk("rst_vsync", int'(vd.vsync), 1);
        chk("rst_active", int'(vd.active), 1);
        chk("rst_hblank", int'(vd.hblank), 0);
        chk("rst_prio_small_x", int'(vsm.x), 0);

        rst_d = 1'b0; ce_d = 1'b1;
        repeat (640) step();
        chk("x640", int'(vd.x), 640);
        chk("hblank_at_640", int'(vd.hblank), 1);
        chk("active_at_640", int'(vd.active), 0);
        repeat (16) step();
        chk("hsync_at_656", int'(vd.hsync), 0);
        repeat (95) step();
        chk("hsync_at_751", int'(vd.hsync), 0);
        step();
        chk("hsync_at_752", int'(vd.hsync), 1);
        repeat (47) step();
        chk("x799", int'(vd.x), 799);
        chk("no_tick_799", int'(vd.line_tick), 0);
        step();
        chk("wrap_x", int'(vd.x), 0);
        chk("wrap_y", int'(vd.y), 1);
        chk("wrap_line_tick", int'(vd.line_tick), 1);
        step();
        chk("line_tick_1clk", int'(vd.line_tick), 0);

        // pix_ce alternating: line period doubles to 1600 clocks
        t_first = -1; t_second = -1;
        for (int i = 0; i < 4000 && t_second < 0; i++) begin
            ce_d = ~i[0];
            step();
            if (vd.line_tick) begin
                if (t_first < 0) t_first = cyc;
                else t_second = cyc;
            end
        end
        chk("half_rate_line_period", t_second - t_first, 1600);

        // reset mid-line at x=300
        ce_d = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 900 && !found; i++) begin
            step();
            found = (vd.x == 10'd300);
        end
        chk("reach_x300", int'(found), 1);
        rst_d = 1'b1;
        step();
        chk("midrst_x", int'(vd.x), 0);
        chk("midrst_y", int'(vd.y), 0);
        chk("midrst_hsync", int'(vd.hsync), 1);
        chk("midrst_line_tick", int'(vd.line_tick), 0);
        rst_d = 1'b0;
        step();
        chk("after_rst_x", int'(vd.x), 1);
        ce_d = 1'b0;

        // ---- small instance: 7-pixel lines, 5-line frames
        rst_s = 1'b0; ce_s = 1'b1;
        t_rel = cyc;
        t_first = -1; t_second = -1;
        for (int i = 0; i < 200 && t_second < 0; i++) begin
            step();
            if (vsm.frame_tick) begin
                if (t_first < 0) begin
                    t_first = cyc;
                    chk("ft_y", int'(vsm.y), 3);
                    chk("ft_x", int'(vsm.x), 0);
                    chk("ft_vblank", int'(vsm.vblank), 1);
                    chk("ft_vsync_vfp0", int'(vsm.vsync), 0);
                end else begin
                    t_second = cyc;
                end
            end
        end
        chk("first_frame_tick_delay", t_first - t_rel, 21);
        chk("frame_period", t_second - t_first, 35);
        step();
        chk("frame_tick_1clk", int'(vsm.frame_tick), 0);

        // corner wrap (6,4) -> (0,0)
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            found = (vsm.x == 3'd6) && (vsm.y == 3'd4);
        end
        chk("reach_corner", int'(found), 1);
        step();
        chk("corner_x", int'(vsm.x), 0);
        chk("corner_y", int'(vsm.y), 0);
        chk("corner_line_tick", int'(vsm.line_tick), 1);
        chk("corner_frame_tick", int'(vsm.frame_tick), 0);
        chk("corner_vblank", int'(vsm.vblank), 0);

        // random pix_ce over ~3 frames, scoreboard checks every clock
        for (int i = 0; i < 240; i++) begin
            ce_s = 1'($urandom_range(0, 1));
            ce_d = 1'($urandom_range(0, 1));
            step();
        end
        ce_d = 1'b0;

        // reset mid-frame at (3,2)
        ce_s = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            found = (vsm.x == 3'd3) && (vsm.y == 3'd2);
        end
        chk("reach_3_2", int'(found), 1);
        rst_s = 1'b1;
        step();
        chk("srst_x", int'(vsm.x), 0);
        chk("srst_y", int'(vsm.y), 0);
        chk("srst_vsync", int'(vsm.vsync), 1);
        chk("srst_vblank", int'(vsm.vblank), 0);
        chk("srst_ticks", int'({vsm.line_tick, vsm.frame_tick}), 0);
        rst_s = 1'b0;
        repeat (10) step();

        @(negedge clk);
        @(negedge clk);
        chk("queues_drained", q_d.size() + q_s.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Generates raster timing for the VT52 display pipeline: horizontal/vertical counters, sync pulses, blanking flags and pixel coordinates. It is the producer of the vblank level that the cursor blinker and the character renderer consume as their frame tick. It runs on the system clock and advances on a pixel clock-enable.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels, >=1)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines, >=1)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, asserted level of hsync
VSYNC_POL, 0, asserted level of vsync
X_BITS, 10, width of x (must hold H_TOTAL-1)
Y_BITS, 10, width of y (must hold V_TOTAL-1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pix_ce  in  1  pixel clock-enable; counters advance only when high
x  out  X_BITS  current horizontal count (0..H_TOTAL-1)
y  out  Y_BITS  current vertical count (0..V_TOTAL-1)
hsync  out  1  horizontal sync, HSYNC_POL when asserted
vsync  out  1  vertical sync, VSYNC_POL when asserted
hblank  out  1  high when x >= H_ACTIVE
vblank  out  1  high when y >= V_ACTIVE (level; feeds blinker tick)
active  out  1  ~hblank & ~vblank
line_tick  out  1  one-clk pulse when x wraps to 0
frame_tick  out  1  one-clk pulse when y enters V_ACTIVE (vblank start)

Behaviour:
- One clock (clk); reset is synchronous and active-high; it takes priority over pix_ce.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Porches may be 0; sync widths >= 1.
- Horizontal region order: ACTIVE [0,H_ACTIVE), FP, SYNC [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), BP; same for vertical.
- On reset: x=0, y=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, hblank=0, vblank=0, active=1, line_tick=0, frame_tick=0.
- pix_ce=0: all outputs hold, except line_tick and frame_tick, which are 0.
- pix_ce=1: x <= (x==H_TOTAL-1) ? 0 : x+1. On x wrap: y <= (y==V_TOTAL-1) ? 0 : y+1; otherwise y holds.
- All outputs are registered and describe the new (x,y) after the same edge, with zero latency between the coordinate and its flags. Flags are decoded from the next-count values.
- hsync is asserted while x is in the H SYNC region; vsync is asserted while y is in the V SYNC region. vsync changes only on line boundaries, together with x=0.
- line_tick=1 on the edge where x becomes 0 through a wrap (not after reset).
- frame_tick=1 on the edge where y becomes V_ACTIVE through a wrap. Exactly one pulse per frame.
- Both wraps coincide at (H_TOTAL-1, V_TOTAL-1) -> (0,0): line_tick=1, frame_tick=0, vblank falls.
- Reset mid-frame: next cycle returns to the reset values; there is no partial-line recovery.
- Counter arithmetic is unsigned; no value outside 0..TOTAL-1 is ever produced.

Decomposition:
- Shared package video_timing_pkg: default 640x480@60 constants (H_/V_ ACTIVE/FP/SYNC/BP) and derived H_TOTAL/V_TOTAL as localparam-style constants.
- One sub-module, video_axis_counter, instantiated for h and v. Its ports are clk, reset, en, count, wrap, next_count, blank, sync_active, parameterised by ACTIVE/FP/SYNC/BP.
- The top level chains h.wrap&pix_ce into v.en and registers the polarity and tick outputs.

Test Plan:
- Reset held 3 clks, then released with pix_ce=1 -> x counts 0,1,2...; first hblank=1 at x=640; hsync low for x=656..751; line_tick pulses at the x 799->0 edge; y=1.
- Full frame at defaults -> vblank rises at y=480 with frame_tick for exactly 1 clk; vsync low for y=490..491; next frame_tick occurs 420000 clks later.
- pix_ce toggling 1,0,1,0 -> line period is 1600 clks; ticks are never high during a pix_ce=0 cycle; outputs are stable during hold cycles.
- Small params H=4/1/1/1, V=3/0/1/1 -> x sequence 0..6 wraps; V_FP=0 gives vsync asserted at the same edge vblank rises; corner wrap (6,4)->(0,0) shows line_tick=1, frame_tick=0.
- Reset asserted at x=300, y=200 with pix_ce=1 -> next clk x=0, y=0, syncs inactive, blanks 0, no tick pulses.
- Random pix_ce over 3 frames -> the scoreboard model matches x, y, all flags, and ticks every clk.
